// File: rtl/can_acf_pkg.sv
// ----------------------------------------------------------------------------
// can_acf_pkg
// Shared definitions for the CAN acceptance filter:
//   - FSM state encodings (IDLE / SCAN / WRITE)
//   - bit positions of the fields inside the 32-bit ID word
//   - helpers to build an ID word and to evaluate one mask/ID pair
// ----------------------------------------------------------------------------
package can_acf_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // ID word field layout (same layout in the message, AFMR and AFIR)
    localparam int ID_STD_MSB = 31;
    localparam int ID_STD_LSB = 21;
    localparam int SRR_BIT    = 20;
    localparam int IDE_BIT    = 19;
    localparam int ID_EXT_MSB = 18;
    localparam int ID_EXT_LSB = 1;
    localparam int RTR_BIT    = 0;

    // Assemble an ID word from its fields.
    function automatic logic [31:0] acf_make_idword(
        input logic [10:0] id_std,
        input logic        srr,
        input logic        ide,
        input logic [17:0] id_ext,
        input logic        rtr
    );
        logic [31:0] w;
        w                         = '0;
        w[ID_STD_MSB:ID_STD_LSB]  = id_std;
        w[SRR_BIT]                = srr;
        w[IDE_BIT]                = ide;
        w[ID_EXT_MSB:ID_EXT_LSB]  = id_ext;
        w[RTR_BIT]                = rtr;
        return w;
    endfunction

    // A filter matches when every bit selected by the mask agrees with the ID.
    function automatic logic acf_id_match(
        input logic [31:0] idword,
        input logic [31:0] mask,
        input logic [31:0] id
    );
        return ((idword ^ id) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/can_acf_match.sv
// ----------------------------------------------------------------------------
// can_acf_match
// Combinational compare of one received ID word against one mask/ID pair.
// Ports:
//   idword  in  32  ID word of the received message
//   mask    in  32  filter mask; 1 = bit is compared
//   id      in  32  filter ID
//   match   out 1   all compared bits agree
// ----------------------------------------------------------------------------
module can_acf_match
    import can_acf_pkg::*;
(
    input  logic [31:0] idword,
    input  logic [31:0] mask,
    input  logic [31:0] id,
    output logic        match
);

    assign match = acf_id_match(idword, mask, id);

endmodule

// File: rtl/can_acceptance_filter_seq.sv
// ----------------------------------------------------------------------------
// can_acceptance_filter_seq
// Acceptance filter between the CAN RX decoder and the RX FIFO. A captured
// message is compared against the mask/ID pairs one filter per cycle; the
// lowest enabled matching filter accepts it and the message is written to the
// FIFO. With filtering disabled (or no filter enabled) messages pass through.
// Ports:
//   sys_clk       in   1               clock
//   IP2Can_reset  in   1               synchronous active-high reset
//   filtering_en  in   1               global enable; 0 = accept all
//   afr_en        in   NUM_FILTERS     per-filter enable
//   afmr_flat     in   32*NUM_FILTERS  masks, filter i at [32*i+31:32*i]
//   afir_flat     in   32*NUM_FILTERS  IDs, same layout
//   rx_valid      in   1               message valid from decoder
//   rx_ready      out  1               block can capture a message
//   rx_message    in   MSG_W           received message
//   rxfifo_full   in   1               RX FIFO full
//   rxfifo_wr     out  1               one-cycle FIFO write strobe
//   rxfifo_ip     out  MSG_W           FIFO write data
//   ACFBSY        out  1               scan/write in progress
//   acf_hit       out  1               pulse: accepted by a filter
//   acf_hit_idx   out  HIDX_W          lowest matching filter, held
//   acf_reject    out  1               pulse: no enabled filter matched
//   acf_ovfl      out  1               pulse: accepted message dropped (FIFO full)
// ----------------------------------------------------------------------------
module can_acceptance_filter_seq
    import can_acf_pkg::*;
#(
    parameter  int NUM_FILTERS = 4,
    parameter  int MSG_W       = 128,
    parameter  int ID_LSB      = 96,
    localparam int HIDX_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                      sys_clk,
    input  logic                      IP2Can_reset,
    input  logic                      filtering_en,
    input  logic [NUM_FILTERS-1:0]    afr_en,
    input  logic [32*NUM_FILTERS-1:0] afmr_flat,
    input  logic [32*NUM_FILTERS-1:0] afir_flat,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic [MSG_W-1:0]          rx_message,
    input  logic                      rxfifo_full,
    output logic                      rxfifo_wr,
    output logic [MSG_W-1:0]          rxfifo_ip,
    output logic                      ACFBSY,
    output logic                      acf_hit,
    output logic [HIDX_W-1:0]         acf_hit_idx,
    output logic                      acf_reject,
    output logic                      acf_ovfl
);

    logic [1:0]             state;
    logic [HIDX_W-1:0]      idx;
    logic [HIDX_W-1:0]      hit_idx_q;
    logic [MSG_W-1:0]       msg_q;
    logic [NUM_FILTERS-1:0] afr_q;

    logic [31:0] sel_mask;
    logic [31:0] sel_id;
    logic        sel_en;
    logic        raw_match;
    logic        scan_match;
    logic        idx_last;

    // Select the filter under test. A plain loop mux stays in range for any
    // NUM_FILTERS, including non-powers of two.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        sel_mask = '0;
        sel_id   = '0;
        sel_en   = 1'b0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (idx == HIDX_W'(i)) begin
                sel_mask = afmr_flat[32*i +: 32];
                sel_id   = afir_flat[32*i +: 32];
                sel_en   = afr_q[i];
            end
        end
    end

    can_acf_match u_match (
        .idword (msg_q[ID_LSB +: 32]),
        .mask   (sel_mask),
        .id     (sel_id),
        .match  (raw_match)
    );

    // A disabled filter still consumes its scan cycle but can never match.
    assign scan_match = (state == ST_SCAN) && sel_en && raw_match;
    assign idx_last   = (idx == HIDX_W'(NUM_FILTERS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (IP2Can_reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hit_idx_q <= '0;
            afr_q     <= '0;
            // NOTE: the message register is reset too so rxfifo_ip reads 0
            // after reset rather than stale data.
            msg_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        msg_q <= rx_message;
                        afr_q <= afr_en;
                        idx   <= '0;
                        // Filter settings are taken at capture; later changes
                        // only apply to the next message.
                        if (!filtering_en || (afr_en == '0))
                            state <= ST_WRITE;
                        else
                            state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_match) begin
                        hit_idx_q <= idx;
                        state     <= ST_WRITE;
                    end else if (idx_last) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + HIDX_W'(1);
                    end
                end
                ST_WRITE: begin
                    // The bus cannot be stalled: write or drop, then move on.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready    = (state == ST_IDLE);
    assign ACFBSY      = (state != ST_IDLE);
    assign acf_hit     = scan_match;
    assign acf_reject  = (state == ST_SCAN) && !scan_match && idx_last;
    assign rxfifo_wr   = (state == ST_WRITE) && !rxfifo_full;
    assign acf_ovfl    = (state == ST_WRITE) && rxfifo_full;
    assign rxfifo_ip   = msg_q;
    // The new index is visible in the same cycle as the hit pulse, then held.
    assign acf_hit_idx = scan_match ? idx : hit_idx_q;

endmodule

// File: tb/tb_can_acceptance_filter_seq.sv
// ----------------------------------------------------------------------------
// tb_can_acceptance_filter_seq
// Directed bench for can_acceptance_filter_seq (NUM_FILTERS=4, MSG_W=128,
// ID_LSB=96). Inputs change 2 ns after the rising edge; outputs are compared
// in the same window, well away from the next edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_can_acceptance_filter_seq;
    import can_acf_pkg::*;

    localparam int NF = 4;
    localparam int MW = 128;
    localparam int HW = 2;

    logic          sys_clk;
    logic          IP2Can_reset;
    logic          filtering_en;
    logic [NF-1:0] afr_en;
    logic [32*NF-1:0] afmr_flat;
    logic [32*NF-1:0] afir_flat;
    logic          rx_valid;
    logic          rx_ready;
    logic [MW-1:0] rx_message;
    logic          rxfifo_full;
    logic          rxfifo_wr;
    logic [MW-1:0] rxfifo_ip;
    logic          ACFBSY;
    logic          acf_hit;
    logic [HW-1:0] acf_hit_idx;
    logic          acf_reject;
    logic          acf_ovfl;

    can_acceptance_filter_seq #(
        .NUM_FILTERS (NF),
        .MSG_W       (MW),
        .ID_LSB      (96)
    ) dut (
        .sys_clk      (sys_clk),
        .IP2Can_reset (IP2Can_reset),
        .filtering_en (filtering_en),
        .afr_en       (afr_en),
        .afmr_flat    (afmr_flat),
        .afir_flat    (afir_flat),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_message   (rx_message),
        .rxfifo_full  (rxfifo_full),
        .rxfifo_wr    (rxfifo_wr),
        .rxfifo_ip    (rxfifo_ip),
        .ACFBSY       (ACFBSY),
        .acf_hit      (acf_hit),
        .acf_hit_idx  (acf_hit_idx),
        .acf_reject   (acf_reject),
        .acf_ovfl     (acf_ovfl)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    // Present a message in IDLE; returns in the first cycle after capture.
    task automatic send(input logic [MW-1:0] m);
        rx_message = m;
        rx_valid   = 1'b1;
        #1;
        check("ready_before_capture", rx_ready, 1);
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic set_filter(input int i, input logic [31:0] mask, input logic [31:0] id);
        afmr_flat[32*i +: 32] = mask;
        afir_flat[32*i +: 32] = id;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic [MW-1:0] msg;
    logic [MW-1:0] msgs [4];

    initial begin
        int sent;
        int got;
        int n;
        int last_wr_n;
        logic accept;

        IP2Can_reset = 1'b1;
        filtering_en = 1'b0;
        afr_en       = '0;
        afmr_flat    = '0;
        afir_flat    = '0;
        rx_valid     = 1'b0;
        rx_message   = '0;
        rxfifo_full  = 1'b0;
        cyc();
        cyc();
        IP2Can_reset = 1'b0;
        #1;

        // Reset state
        check("rst_ready",   rx_ready,    1);
        check("rst_busy",    ACFBSY,      0);
        check("rst_wr",      rxfifo_wr,   0);
        check("rst_ip",      rxfifo_ip,   0);
        check("rst_hit",     acf_hit,     0);
        check("rst_hit_idx", acf_hit_idx, 0);
        check("rst_reject",  acf_reject,  0);
        check("rst_ovfl",    acf_ovfl,    0);

        // 1. Pass-through: write one cycle after capture
        msg = {32'h1234_5678, 96'hA5A5_0001_0203_0405_0607_0809};
        send(msg);
        check("pt_wr",    rxfifo_wr, 1);
        check("pt_ip",    rxfifo_ip, msg);
        check("pt_hit",   acf_hit,   0);
        check("pt_busy",  ACFBSY,    1);
        check("pt_ready", rx_ready,  0);
        cyc();
        check("pt_wr_end",    rxfifo_wr, 0);
        check("pt_ready_end", rx_ready,  1);

        // 2. Filter 2 only; filter 0 mask 0 would match all but is disabled
        filtering_en = 1'b1;
        afr_en       = 4'b0100;
        set_filter(0, 32'h0000_0000, 32'h0000_0000);
        set_filter(1, 32'hFFFF_FFFF, 32'h0000_0000);
        set_filter(2, 32'hFFE0_0000, 32'h2460_0000);
        set_filter(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        msg = {32'h247F_FFFF, 96'h1111_2222_3333_4444_5555_6666};
        send(msg);                                   // capture+1, idx0
        check("f2_hit_c1",  acf_hit, 0);
        check("f2_busy_c1", ACFBSY,  1);
        cyc();                                       // capture+2, idx1
        check("f2_hit_c2",  acf_hit, 0);
        cyc();                                       // capture+3, idx2
        check("f2_hit_c3",  acf_hit,     1);
        check("f2_idx_c3",  acf_hit_idx, 2);
        check("f2_wr_c3",   rxfifo_wr,   0);
        cyc();                                       // capture+4, WRITE
        check("f2_wr_c4",   rxfifo_wr,   1);
        check("f2_ip_c4",   rxfifo_ip,   msg);
        check("f2_hit_c4",  acf_hit,     0);
        check("f2_idx_c4",  acf_hit_idx, 2);
        cyc();
        check("f2_ready_c5", rx_ready,  1);
        check("f2_wr_c5",    rxfifo_wr, 0);

        msg = {32'h2480_0000, 96'h7777_8888_9999_AAAA_BBBB_CCCC};
        send(msg);
        cyc();
        cyc();                                       // capture+3
        check("rj_reject_c3", acf_reject, 0);
        cyc();                                       // capture+4, idx3
        check("rj_reject_c4", acf_reject, 1);
        check("rj_wr_c4",     rxfifo_wr,  0);
        check("rj_hit_c4",    acf_hit,    0);
        cyc();
        check("rj_reject_c5", acf_reject,  0);
        check("rj_wr_c5",     rxfifo_wr,   0);
        check("rj_ready_c5",  rx_ready,    1);
        check("rj_idx_held",  acf_hit_idx, 2);

        // 3. Filters 1 and 3 both match; lowest index wins, scan stops at 1
        afr_en = 4'b1010;
        set_filter(1, 32'h0000_0000, 32'h0000_0000);
        set_filter(3, 32'h0000_0000, 32'h0000_0000);
        msg = {32'hDEAD_BEEF, 96'h0};
        send(msg);
        check("lo_hit_c1", acf_hit, 0);
        cyc();                                       // capture+2, idx1
        check("lo_hit_c2", acf_hit,     1);
        check("lo_idx_c2", acf_hit_idx, 1);
        cyc();                                       // capture+3, WRITE
        check("lo_wr_c3",  rxfifo_wr, 1);
        check("lo_ip_c3",  rxfifo_ip, msg);
        check("lo_hit_c3", acf_hit,   0);
        cyc();
        check("lo_ready_c4", rx_ready,    1);
        check("lo_hit_c4",   acf_hit,     0);
        check("lo_idx_c4",   acf_hit_idx, 1);

        // 4. Accepted while FIFO full: overflow pulse, no write
        rxfifo_full = 1'b1;
        msg = {32'h0BAD_F00D, 96'h5};
        send(msg);
        cyc();
        check("ov_hit_c2",  acf_hit,   1);
        check("ov_ovfl_c2", acf_ovfl,  0);
        cyc();
        check("ov_ovfl_c3", acf_ovfl,  1);
        check("ov_wr_c3",   rxfifo_wr, 0);
        cyc();
        check("ov_ready_c4", rx_ready, 1);
        check("ov_ovfl_c4",  acf_ovfl, 0);
        rxfifo_full = 1'b0;

        // 5. Reset while scanning idx1 (previous hit index is 1 -> must clear)
        afr_en = 4'b0100;
        msg = {32'h247F_FFFF, 96'h9};
        send(msg);                                   // idx0
        cyc();                                       // idx1
        check("mr_busy", ACFBSY, 1);
        IP2Can_reset = 1'b1;
        cyc();
        IP2Can_reset = 1'b0;
        #1;
        check("mr_ready",  rx_ready,    1);
        check("mr_busy0",  ACFBSY,      0);
        check("mr_hit",    acf_hit,     0);
        check("mr_reject", acf_reject,  0);
        check("mr_wr",     rxfifo_wr,   0);
        check("mr_ovfl",   acf_ovfl,    0);
        check("mr_idx",    acf_hit_idx, 0);
        cyc();
        check("mr_no_late_wr",  rxfifo_wr, 0);
        check("mr_no_late_hit", acf_hit,   0);

        // Back-to-back with rx_valid held high (pass-through): captures every
        // other cycle, writes land on cycles 1,3,5,7.
        filtering_en = 1'b0;
        for (int i = 0; i < 4; i++)
            msgs[i] = {acf_make_idword(11'(16'h100 + i), 1'b1, 1'b1, 18'(i * 3), i[0]),
                       96'(i + 32'hC0DE_0000)};
        sent      = 0;
        got       = 0;
        last_wr_n = 0;
        n         = 0;
        while (got < 4 && n < 30) begin
            if (sent < 4) begin
                rx_message = msgs[sent];
                rx_valid   = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            #1;
            accept = rx_valid && rx_ready;
            cyc();
            n++;
            if (accept) sent++;
            if (rxfifo_wr) begin
                if (got < 4) check("b2b_data", rxfifo_ip, msgs[got]);
                got++;
                last_wr_n = n;
            end
        end
        rx_valid = 1'b0;
        check("b2b_count",    got,       4);
        check("b2b_last_cyc", last_wr_n, 7);
        cyc();
        check("b2b_ready_end", rx_ready,  1);
        check("b2b_wr_end",    rxfifo_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
